memory_round_ctrl: RTL and testbench

- Round sequencer for the Memory Matrix game. Sits between the LFSR board generator and the display/input logic.
- Draws a non-zero 8-tile board from the generator and shows it for a fixed time, then hides it.
- Scores player tile guesses against the board and declares win or lose.
- Owns the generator enable; the generator itself is outside this block.

---
 rtl/memory_round_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_memory_round_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_round_ctrl.sv
// Round sequencer for the Memory Matrix game: draws a board, shows it, scores guesses.
// Optional play-phase timeout is enabled by defining MEMMTX_TIMEOUT_EN.
module memory_round_ctrl #(
  parameter int unsigned SHOW_CYCLES  = 25000000,
  parameter int unsigned MAX_MISTAKES = 3,
  parameter int unsigned PLAY_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lfsr_value,
  output logic       lfsr_en,
  output logic [7:0] board_out,
  output logic       show,
  output logic [7:0] found,
  input  logic       guess_valid,
  input  logic [2:0] guess_idx,
  output logic [7:0] score,
  output logic [3:0] mistakes,
  output logic       win,
  output logic       lose,
  output logic       round_done
);

  localparam int unsigned SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int unsigned PLAY_W = (PLAY_CYCLES > 1) ? $clog2(PLAY_CYCLES) : 1;
  localparam logic [3:0]  MAX_M  = 4'(MAX_MISTAKES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GEN  = 3'd1,
    SHOW = 3'd2,
    PLAY = 3'd3,
    WIN  = 3'd4,
    LOSE = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic              start_q;
  logic              start_rise;
  logic [7:0]        board, board_nxt;
  logic [SHOW_W-1:0] show_cnt, show_cnt_nxt;
  logic [7:0]        found_nxt;
  logic [7:0]        score_nxt;
  logic [3:0]        mistakes_nxt;
  logic [7:0]        new_bit;
  logic              hit;
  logic              timeout;

  // Edge history follows the key even during reset, so a key held through reset never starts a round.
  always_ff @(posedge clk) begin
    start_q <= start;
  end

  assign start_rise = start & ~start_q;
  assign new_bit    = 8'b1 << guess_idx;
  assign hit        = board[guess_idx];

`ifdef MEMMTX_TIMEOUT_EN
  logic [PLAY_W-1:0] play_cnt, play_cnt_nxt;

  assign timeout = (state == PLAY) && (play_cnt == '0);

  always_comb begin
    play_cnt_nxt = play_cnt;
    if (state == SHOW && show_cnt == '0) begin
      play_cnt_nxt = PLAY_W'(PLAY_CYCLES - 1);
    end else if (state == PLAY && play_cnt != '0) begin
      play_cnt_nxt = play_cnt - PLAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      play_cnt <= '0;
    end else begin
      play_cnt <= play_cnt_nxt;
    end
  end
`else
  logic [PLAY_W-1:0] unused_play;

  assign unused_play = '0;
  assign timeout     = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_nxt    = state;
    board_nxt    = board;
    show_cnt_nxt = show_cnt;
    found_nxt    = found;
    score_nxt    = score;
    mistakes_nxt = mistakes;

    case (state)
      IDLE: begin
        if (start_rise) state_nxt = GEN;
      end
      GEN: begin
        if (lfsr_value != 8'h00) begin
          board_nxt    = lfsr_value;
          show_cnt_nxt = SHOW_W'(SHOW_CYCLES - 1);
          found_nxt    = 8'h00;
          mistakes_nxt = 4'd0;
          state_nxt    = SHOW;
        end
      end
      SHOW: begin
        if (show_cnt == '0) begin
          state_nxt = PLAY;
        end else begin
          show_cnt_nxt = show_cnt - SHOW_W'(1);
        end
      end
      PLAY: begin
        if (guess_valid) begin
          if (hit) begin
            if (!found[guess_idx]) begin
              found_nxt = found | new_bit;
              score_nxt = (score == 8'hFF) ? score : score + 8'd1;
            end
          end else begin
            mistakes_nxt = mistakes + 4'd1;
          end
        end
        // A winning guess outranks both the mistake limit and the timer.
        if (guess_valid && hit && ((found | new_bit) == board)) begin
          state_nxt = WIN;
        end else if (guess_valid && !hit && (mistakes + 4'd1 == MAX_M)) begin
          state_nxt = LOSE;
        end else if (timeout) begin
          state_nxt = LOSE;
        end
      end
      WIN: begin
        if (start_rise) state_nxt = GEN;
      end
      LOSE: begin
        if (start_rise) begin
          score_nxt = 8'h00;
          state_nxt = GEN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      board      <= 8'h00;
      show_cnt   <= '0;
      found      <= 8'h00;
      score      <= 8'h00;
      mistakes   <= 4'd0;
      lfsr_en    <= 1'b1;
      show       <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      board      <= board_nxt;
      show_cnt   <= show_cnt_nxt;
      found      <= found_nxt;
      score      <= score_nxt;
      mistakes   <= mistakes_nxt;
      lfsr_en    <= (state_nxt == IDLE) || (state_nxt == GEN);
      show       <= (state_nxt == SHOW);
      win        <= (state_nxt == WIN);
      lose       <= (state_nxt == LOSE);
      round_done <= ((state_nxt == WIN) && (state != WIN)) ||
                    ((state_nxt == LOSE) && (state != LOSE));
    end
  end

  assign board_out = show ? board : 8'h00;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Scoreboard bench for memory_round_ctrl: directed test-plan rounds plus random rounds
// checked against a round-level model; timeout scenarios run when MEMMTX_TIMEOUT_EN is defined.
module tb_memory_round_ctrl;

  localparam int unsigned SHOW_CYCLES  = 4;
  localparam int unsigned MAX_MISTAKES = 3;
  localparam int unsigned PLAY_CYCLES  = 10;
`ifdef MEMMTX_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] lfsr_value = 8'h00;
  logic       lfsr_en;
  logic [7:0] board_out;
  logic       show;
  logic [7:0] found;
  logic       guess_valid = 1'b0;
  logic [2:0] guess_idx = 3'd0;
  logic [7:0] score;
  logic [3:0] mistakes;
  logic       win;
  logic       lose;
  logic       round_done;

  memory_round_ctrl #(
    .SHOW_CYCLES (SHOW_CYCLES),
    .MAX_MISTAKES(MAX_MISTAKES),
    .PLAY_CYCLES (PLAY_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .lfsr_value (lfsr_value),
    .lfsr_en    (lfsr_en),
    .board_out  (board_out),
    .show       (show),
    .found      (found),
    .guess_valid(guess_valid),
    .guess_idx  (guess_idx),
    .score      (score),
    .mistakes   (mistakes),
    .win        (win),
    .lose       (lose),
    .round_done (round_done)
  );

  always #5 clk = ~clk;

  // kind 0: board reveal expected; kind 1: round end expected
  typedef struct {
    int         kind;
    logic [7:0] board;
    logic [7:0] found;
    int         score;
    int         mistakes;
    logic       win;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Round-level reference model
  logic [7:0] m_board = 8'h00;
  logic [7:0] m_found = 8'h00;
  int         m_score = 0;
  int         m_mist  = 0;
  bit         m_lost  = 1'b0;
  int         guess_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT reveals a board or ends a round
  logic show_prev = 1'b0;
  logic rd_prev   = 1'b0;
  int   show_len  = 0;
  exp_t me;

  always @(negedge clk) begin
    if (show && !show_prev) begin
      if (sb.size() == 0) begin
        check("sb_underflow_show", 32'd0, 32'd1);
      end else begin
        me = sb.pop_front();
        check("sb_kind_show", 32'(me.kind), 32'd0);
        check("board_out_shown", 32'(board_out), 32'(me.board));
      end
      show_len = 1;
    end else if (show) begin
      show_len++;
    end
    if (show_prev && !show && reset) begin
      check("show_len", 32'(show_len), 32'(SHOW_CYCLES));
      check("board_out_hidden", 32'(board_out), 32'd0);
    end
    if (rd_prev) check("round_done_pulse", 32'(round_done), 32'd0);
    if (round_done) begin
      if (sb.size() == 0) begin
        check("sb_underflow_done", 32'd0, 32'd1);
      end else begin
        me = sb.pop_front();
        check("sb_kind_done", 32'(me.kind), 32'd1);
        check("win", 32'(win), 32'(me.win));
        check("lose", 32'(lose), 32'(!me.win));
        check("found_end", 32'(found), 32'(me.found));
        check("score_end", 32'(score), 32'(me.score));
        check("mistakes_end", 32'(mistakes), 32'(me.mistakes));
      end
    end
    show_prev = show;
    rd_prev   = round_done;
  end

  task automatic check_idle(input string tag);
    check({tag, "_lfsr_en"}, 32'(lfsr_en), 32'd1);
    check({tag, "_show"}, 32'(show), 32'd0);
    check({tag, "_board_out"}, 32'(board_out), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_mistakes"}, 32'(mistakes), 32'd0);
    check({tag, "_win_lose"}, 32'({win, lose}), 32'd0);
    check({tag, "_round_done"}, 32'(round_done), 32'd0);
  endtask

  task automatic start_round(input logic [7:0] b, input int zeros);
    exp_t e;
    int   k;
    if (m_lost) m_score = 0;
    m_lost  = 1'b0;
    m_board = b;
    m_found = 8'h00;
    m_mist  = 0;
    e = '{kind: 0, board: b, found: 8'h00, score: 0, mistakes: 0, win: 1'b0};
    sb.push_back(e);
    lfsr_value = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < zeros; i++) begin
      lfsr_value = 8'h00;
      @(negedge clk);
      check("gen_hold_lfsr_en", 32'(lfsr_en), 32'd1);
      check("gen_hold_show", 32'(show), 32'd0);
    end
    lfsr_value = b;
    k = 0;
    while (!show && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("show_seen", 32'(show), 32'd1);
    lfsr_value = 8'($urandom);
    k = 0;
    // Guesses during the reveal must be dropped
    while (show && k < 20) begin
      check("show_lfsr_en", 32'(lfsr_en), 32'd0);
      guess_valid = 1'($urandom);
      guess_idx   = 3'($urandom);
      @(negedge clk);
      k++;
    end
    guess_valid = 1'b0;
    check("play_found_clear", 32'(found), 32'd0);
  endtask

  task automatic play(input bit rnd, output bit term);
    int   slot;
    int   g;
    bit   w;
    bit   l;
    exp_t e;
    term = 1'b0;
    slot = 1;
    while (!term && slot <= 200) begin
      if (guess_q.size() > 0) g = guess_q.pop_front();
      else if (rnd) g = ($urandom_range(0, 9) < 3) ? -1 : int'($urandom_range(0, 7));
      else if (TO) g = -1;
      else break;
      w = 1'b0;
      l = 1'b0;
      if (g >= 0) begin
        if (m_board[g]) begin
          if (!m_found[g]) begin
            m_found[g] = 1'b1;
            if (m_score < 255) m_score++;
          end
          w = (m_found == m_board);
        end else begin
          m_mist++;
          l = (m_mist == int'(MAX_MISTAKES));
        end
        guess_valid = 1'b1;
        guess_idx   = 3'(g);
      end else begin
        guess_valid = 1'b0;
      end
      if (TO && !w && !l && slot == int'(PLAY_CYCLES)) l = 1'b1;
      if (w || l) begin
        e = '{kind: 1, board: m_board, found: m_found, score: m_score,
              mistakes: m_mist, win: w};
        sb.push_back(e);
        m_lost = l;
        term   = 1'b1;
      end
      @(negedge clk);
      guess_valid = 1'b0;
      if (g >= 0) begin
        check("found_step", 32'(found), 32'(m_found));
        check("score_step", 32'(score), 32'(m_score));
        check("mistakes_step", 32'(mistakes), 32'(m_mist));
      end
      slot++;
    end
    if (rnd && !term) check("play_bound", 32'd0, 32'd1);
  endtask

  task automatic set_guesses(input int n, input int a0, input int a1, input int a2);
    guess_q.delete();
    if (n > 0) guess_q.push_back(a0);
    if (n > 1) guess_q.push_back(a1);
    if (n > 2) guess_q.push_back(a2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    @(negedge clk);

    // Reveal timing and lose by mistakes on board A5
    start_round(8'hA5, 0);
    set_guesses(3, 1, 3, 4);
    play(1'b0, t);
    // Zero draws held in GEN, then win on 81 with a repeated guess
    start_round(8'h81, 3);
    set_guesses(3, 7, 7, 0);
    play(1'b0, t);
    // Lose on 81 keeps the score until the next start
    start_round(8'h81, 0);
    set_guesses(3, 1, 2, 3);
    play(1'b0, t);
    start_round(8'h03, 0);
    check("lose_start_score", 32'(score), 32'd0);
    check("lose_start_mistakes", 32'(mistakes), 32'd0);
    set_guesses(1, 0, 0, 0);
    play(1'b0, t);

    // Reset mid-play with start held through reset release
    reset = 1'b0;
    start = 1'b1;
    lfsr_value = 8'h5A;
    @(negedge clk);
    check_idle("midplay_reset");
    reset = 1'b1;
    m_score = 0;
    m_lost  = 1'b0;
    repeat (5) @(negedge clk);
    check("held_start_show", 32'(show), 32'd0);
    check("held_start_lfsr_en", 32'(lfsr_en), 32'd1);
    start = 1'b0;
    @(negedge clk);

`ifdef MEMMTX_TIMEOUT_EN
    start_round(8'h10, 0);
    guess_q.delete();
    play(1'b0, t);
    start_round(8'h10, 0);
    guess_q.delete();
    for (int i = 0; i < 9; i++) guess_q.push_back(-1);
    guess_q.push_back(4);
    play(1'b0, t);
`endif

    for (int r = 0; r < 30; r++) begin
      guess_q.delete();
      start_round(8'($urandom_range(1, 255)), int'($urandom_range(0, 2)));
      play(1'b1, t);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
